// File: rtl/gate_test_sequencer_if.sv
// Signal bundle between the gate self-check sequencer and the gates/host it drives.
// slave = sequencer side, master = host plus gates under test.
interface gate_test_sequencer_if #(
    parameter int ERR_W = 8
);
    logic             start;
    logic             in_not;
    logic             in1_nand;
    logic             in2_nand;
    logic             out_not;
    logic             out_nand;
    logic             busy;
    logic             done;
    logic             pass;
    logic [ERR_W-1:0] err_count;
    logic [3:0]       fail_vec;

    modport slave (
        input  start, out_not, out_nand,
        output in_not, in1_nand, in2_nand, busy, done, pass, err_count, fail_vec
    );

    modport master (
        output start, out_not, out_nand,
        input  in_not, in1_nand, in2_nand, busy, done, pass, err_count, fail_vec
    );
endinterface

// File: rtl/gate_test_sequencer.sv
// Walks a NOT gate and a 2-input NAND gate through all four input vectors,
// waits a settle time per vector and accumulates mismatch results.
//
//   state  | meaning
//   IDLE   | waiting for start; results of last run held
//   APPLY  | vector just driven; arm settle timer
//   SETTLE | hold vector for SETTLE_CYCLES cycles
//   CHECK  | compare gate outputs against registered stimulus, step vector
//   DONE   | one-cycle done pulse, release busy
module gate_test_sequencer #(
    parameter int SETTLE_CYCLES = 4,
    parameter int REPEAT        = 1,
    parameter int ERR_W         = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    gate_test_sequencer_if.slave  bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_APPLY,
        S_SETTLE,
        S_CHECK,
        S_DONE
    } state_t;

    localparam int CNT_W  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int PCNT_W = (REPEAT > 1) ? $clog2(REPEAT) : 1;
    localparam logic [CNT_W-1:0]  SETTLE_LOAD = CNT_W'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
    localparam logic [PCNT_W-1:0] PASS_LAST   = PCNT_W'(REPEAT - 1);
    localparam logic [ERR_W-1:0]  ERR_MAX     = '1;

    state_t             state;
    logic [1:0]         idx;
    logic [PCNT_W-1:0]  pass_cnt;
    logic [CNT_W-1:0]   settle_cnt;
    logic               in_not_r;
    logic               in1_r;
    logic               in2_r;
    logic               busy_r;
    logic               done_r;
    logic               pass_r;
    logic [ERR_W-1:0]   err_r;
    logic [3:0]         fail_r;

    logic               mismatch;
    logic [ERR_W-1:0]   err_next;
    logic [1:0]         idx_inc;

    // Compare against the registered stimulus so the vector stepped on the
    // CHECK exit edge never leaks into the check of the current one.
    always_comb begin
        mismatch = 1'b0;
        err_next = err_r;
        idx_inc  = idx + 2'd1;
        if ((bus.out_not != ~in_not_r) || (bus.out_nand != ~(in1_r & in2_r))) begin
            mismatch = 1'b1;
        end
        if (mismatch && (err_r != ERR_MAX)) begin
            err_next = err_r + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            idx        <= 2'd0;
            pass_cnt   <= '0;
            settle_cnt <= '0;
            in_not_r   <= 1'b0;
            in1_r      <= 1'b0;
            in2_r      <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            pass_r     <= 1'b0;
            err_r      <= '0;
            fail_r     <= 4'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        err_r    <= '0;
                        fail_r   <= 4'd0;
                        pass_r   <= 1'b0;
                        idx      <= 2'd0;
                        pass_cnt <= '0;
                        busy_r   <= 1'b1;
                        in_not_r <= 1'b0;
                        in1_r    <= 1'b0;
                        in2_r    <= 1'b0;
                        state    <= S_APPLY;
                    end
                end
                S_APPLY: begin
                    settle_cnt <= SETTLE_LOAD;
                    state      <= (SETTLE_CYCLES == 0) ? S_CHECK : S_SETTLE;
                end
                S_SETTLE: begin
                    if (settle_cnt == '0) begin
                        state <= S_CHECK;
                    end else begin
                        settle_cnt <= settle_cnt - 1'b1;
                    end
                end
                S_CHECK: begin
                    err_r <= err_next;
                    if (mismatch) begin
                        fail_r[idx] <= 1'b1;
                    end
                    if (idx != 2'd3) begin
                        idx      <= idx_inc;
                        in1_r    <= idx_inc[1];
                        in2_r    <= idx_inc[0];
                        in_not_r <= idx_inc[0];
                        state    <= S_APPLY;
                    end else if (pass_cnt != PASS_LAST) begin
                        idx      <= 2'd0;
                        pass_cnt <= pass_cnt + 1'b1;
                        in1_r    <= 1'b0;
                        in2_r    <= 1'b0;
                        in_not_r <= 1'b0;
                        state    <= S_APPLY;
                    end else begin
                        done_r <= 1'b1;
                        pass_r <= (err_next == '0);
                        state  <= S_DONE;
                    end
                end
                S_DONE: begin
                    done_r <= 1'b0;
                    busy_r <= 1'b0;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.in_not    = in_not_r;
    assign bus.in1_nand  = in1_r;
    assign bus.in2_nand  = in2_r;
    assign bus.busy      = busy_r;
    assign bus.done      = done_r;
    assign bus.pass      = pass_r;
    assign bus.err_count = err_r;
    assign bus.fail_vec  = fail_r;
endmodule

// File: tb/tb_gate_test_sequencer.sv
// Directed bench for gate_test_sequencer: three parameterisations with modelled
// good/faulty gates, expected run results queued at start and popped at done.
module tb_gate_test_sequencer;
    logic clk;
    logic reset;
    int   n_cmp;
    int   n_mis;
    int   mode0;

    typedef struct {
        int err;
        int fv;
        int pas;
        int lat;
    } exp_t;
    exp_t sb[$];

    gate_test_sequencer_if #(.ERR_W(8)) if0 ();
    gate_test_sequencer_if #(.ERR_W(2)) if1 ();
    gate_test_sequencer_if #(.ERR_W(8)) if2 ();

    gate_test_sequencer #(.SETTLE_CYCLES(4), .REPEAT(1), .ERR_W(8)) u0 (.clk(clk), .reset(reset), .bus(if0));
    gate_test_sequencer #(.SETTLE_CYCLES(4), .REPEAT(3), .ERR_W(2)) u1 (.clk(clk), .reset(reset), .bus(if1));
    gate_test_sequencer #(.SETTLE_CYCLES(0), .REPEAT(1), .ERR_W(8)) u2 (.clk(clk), .reset(reset), .bus(if2));

    // mode0: 0 good gates, 1 NAND output forced high, 2 NOT output stuck low
    assign if0.out_not  = (mode0 == 2) ? 1'b0 : ~if0.in_not;
    assign if0.out_nand = (mode0 == 1) ? 1'b1 : ~(if0.in1_nand & if0.in2_nand);
    assign if1.out_not  = 1'b0;
    assign if1.out_nand = 1'b0;
    assign if2.out_not  = ~if2.in_not;
    assign if2.out_nand = ~(if2.in1_nand & if2.in2_nand);

    logic       start_w[3];
    logic       done_w[3];
    logic       busy_w[3];
    logic       pass_w[3];
    logic [7:0] err_w[3];
    logic [3:0] fv_w[3];
    logic [2:0] stim_w[3];

    assign if0.start = start_w[0];
    assign if1.start = start_w[1];
    assign if2.start = start_w[2];
    assign done_w[0] = if0.done;
    assign done_w[1] = if1.done;
    assign done_w[2] = if2.done;
    assign busy_w[0] = if0.busy;
    assign busy_w[1] = if1.busy;
    assign busy_w[2] = if2.busy;
    assign pass_w[0] = if0.pass;
    assign pass_w[1] = if1.pass;
    assign pass_w[2] = if2.pass;
    assign err_w[0]  = if0.err_count;
    assign err_w[1]  = {6'd0, if1.err_count};
    assign err_w[2]  = if2.err_count;
    assign fv_w[0]   = if0.fail_vec;
    assign fv_w[1]   = if1.fail_vec;
    assign fv_w[2]   = if2.fail_vec;
    assign stim_w[0] = {if0.in_not, if0.in1_nand, if0.in2_nand};
    assign stim_w[1] = {if1.in_not, if1.in1_nand, if1.in2_nand};
    assign stim_w[2] = {if2.in_not, if2.in1_nand, if2.in2_nand};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run(input int w, input int s, input int r, input int exp_err,
                       input int exp_fv, input int exp_pass, input bit repulse);
        exp_t       e;
        int         cyc;
        int         budget;
        int         lat;
        logic [1:0] k;
        lat    = 4 * r * (s + 2);
        budget = lat + 10;
        sb.push_back('{err: exp_err, fv: exp_fv, pas: exp_pass, lat: lat});
        @(negedge clk);
        start_w[w] = 1'b1;
        @(posedge clk);
        #1;
        start_w[w] = 1'b0;
        cyc = 0;
        chk("busy_at_start", {31'd0, busy_w[w]}, 32'd1);
        while (!done_w[w] && cyc < budget) begin
            if ((cyc % (s + 2)) == 0 && cyc < lat) begin
                k = 2'((cyc / (s + 2)) % 4);
                chk("stim_vector", {29'd0, stim_w[w]}, {29'd0, k[0], k[1], k[0]});
            end
            if (repulse && cyc == 3) start_w[w] = 1'b1;
            if (repulse && cyc == 4) start_w[w] = 1'b0;
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("done_seen", {31'd0, done_w[w]}, 32'd1);
        e = sb.pop_front();
        chk("done_latency", cyc, e.lat);
        chk("err_count", {24'd0, err_w[w]}, e.err);
        chk("fail_vec", {28'd0, fv_w[w]}, e.fv);
        chk("pass", {31'd0, pass_w[w]}, e.pas);
        @(posedge clk);
        #1;
        chk("done_one_cycle", {31'd0, done_w[w]}, 32'd0);
        chk("busy_released", {31'd0, busy_w[w]}, 32'd0);
        chk("stim_hold_last", {29'd0, stim_w[w]}, 32'd7);
        repeat (3) @(posedge clk);
        #1;
        chk("pass_held", {31'd0, pass_w[w]}, e.pas);
        chk("err_held", {24'd0, err_w[w]}, e.err);
    endtask

    initial begin
        int cyc;
        int dones;
        n_cmp = 0;
        n_mis = 0;
        mode0 = 0;
        for (int i = 0; i < 3; i++) start_w[i] = 1'b0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 3; i++) begin
            chk("reset_busy", {31'd0, busy_w[i]}, 32'd0);
            chk("reset_done", {31'd0, done_w[i]}, 32'd0);
            chk("reset_pass", {31'd0, pass_w[i]}, 32'd0);
            chk("reset_err", {24'd0, err_w[i]}, 32'd0);
            chk("reset_fail_vec", {28'd0, fv_w[i]}, 32'd0);
            chk("reset_stim", {29'd0, stim_w[i]}, 32'd0);
        end

        run(0, 4, 1, 0, 4'b0000, 1, 1'b0);
        mode0 = 1;
        run(0, 4, 1, 1, 4'b1000, 0, 1'b0);
        mode0 = 2;
        run(0, 4, 1, 2, 4'b0101, 0, 1'b0);

        // abort a good run while vector 2 is settling
        mode0 = 0;
        @(negedge clk);
        start_w[0] = 1'b1;
        @(posedge clk);
        #1;
        start_w[0] = 1'b0;
        dones = 0;
        for (int i = 0; i < 14; i++) begin
            if (done_w[0]) dones++;
            @(posedge clk);
            #1;
        end
        chk("abort_mid_vector2", {29'd0, stim_w[0]}, 32'd2);
        #2;
        reset = 1'b1;
        #1;
        chk("abort_busy", {31'd0, busy_w[0]}, 32'd0);
        chk("abort_stim", {29'd0, stim_w[0]}, 32'd0);
        chk("abort_err", {24'd0, err_w[0]}, 32'd0);
        chk("abort_fail_vec", {28'd0, fv_w[0]}, 32'd0);
        chk("abort_pass", {31'd0, pass_w[0]}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (cyc = 0; cyc < 30; cyc++) begin
            @(posedge clk);
            #1;
            if (done_w[0] || busy_w[0]) dones++;
        end
        chk("abort_no_done", dones, 32'd0);
        run(0, 4, 1, 0, 4'b0000, 1, 1'b0);

        // both outputs stuck low: vectors 0..2 fail, vector 3 matches (NOT=0, NAND=0)
        run(1, 4, 3, 3, 4'b0111, 0, 1'b0);
        run(2, 0, 1, 0, 4'b0000, 1, 1'b1);

        chk("scoreboard_empty", sb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
